// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int N_RD_DEF     = 2;

    // Smallest width able to index n entries (ceil(log2(n))).
    function automatic int addr_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy (pending-producer) vector for the register file. Register 0 has no bit,
// so it can never be marked pending; out-of-range addresses match no bit.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic [NUM_REGS-1:1] busy
);

    // Issue sets, write-back clears; issue wins on the same register since it
    // names a newer producer. Re-issue and stray write-backs need no special case.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (iss_en && iss_addr == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (wr_en && wr_addr == ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and a busy scoreboard per register.
// Register 0 is hard zero; addresses beyond NUM_REGS read as 0 and are never written.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int N_RD     = N_RD_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy
);

    // No storage for register 0: its reads fall through to the zero default.
    logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy;

    regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy)
    );

    // Data array write; reset clears everything and overrides a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bsy;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Only valid nonzero addresses match; a write-back to the same register
        // this cycle is forwarded and hides the still-set busy bit.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    if (wr_en && wr_addr == addr) begin
                        data = wr_data;
                        bsy  = 1'b0;
                    end else begin
                        data = regs[i];
                        bsy  = busy[i];
                    end
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]                  = bsy;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter NUM_REGS, default 32: register count (2..64); ADDR_W = clog2(NUM_REGS), derived, not overridable.
REQ-003 Parameter N_RD, default 2: read port count (1..4).
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: one clock; reset synchronous, active-high.
REQ-006 Port wr_en, input, 1: write-back strobe.
REQ-007 Port wr_addr, input, ADDR_W: write-back destination.
REQ-008 Port wr_data, input, DATA_W: write-back value.
REQ-009 Port iss_en, input, 1: issue strobe; marks destination pending.
REQ-010 Port iss_addr, input, ADDR_W: issued destination.
REQ-011 Port rd_addr, input, N_RD*ADDR_W: read addresses, port k in slice k.
REQ-012 Port rd_data, output, N_RD*DATA_W: read data, port k in slice k.
REQ-013 Port rd_busy, output, N_RD: port k operand still pending.

Function
REQ-014 Storage: NUM_REGS x DATA_W registers plus NUM_REGS-bit busy vector.
REQ-015 Write: at edge with wr_en=1, reg[wr_addr] <= wr_data; single-cycle latency.
REQ-016 Register 0: reads 0, writes ignored, busy never set.
REQ-017 Addresses >= NUM_REGS (non-power-of-2 NUM_REGS): read 0, busy 0, writes/issues ignored.
REQ-018 Read: combinational, zero latency; each port independent, any ports may share an address.
REQ-019 Bypass: wr_en=1 and wr_addr==rd_addr[k]!=0 -> rd_data[k]=wr_data same cycle (write-through).
REQ-020 Busy set: at edge with iss_en=1, iss_addr!=0 -> busy[iss_addr]<=1.
REQ-021 Busy clear: at edge with wr_en=1 -> busy[wr_addr]<=0.
REQ-022 Same-register issue and write-back in one cycle: set wins (new producer); data still written.
REQ-023 Different-register issue and write-back in one cycle: both take effect.
REQ-024 rd_busy[k] = busy[rd_addr[k]], forced 0 when bypass of REQ-019 active for port k.
REQ-025 Re-issue of an already-busy register: stays busy; no error, no counting.
REQ-026 Write-back to a non-busy register: data written, busy stays 0.

Reset
REQ-027 reset=1 at edge: all registers 0, busy vector 0; dominates wr_en and iss_en same cycle.
REQ-028 During reset cycle outputs remain combinational from pre-reset state incl. bypass; after edge rd_data=0, rd_busy=0 for all ports.
REQ-029 Reset mid-sequence: pending issues discarded; later write-backs treated per REQ-026.

Structure
REQ-030 Shared package regfile_pkg holds DATA_W/NUM_REGS/N_RD defaults and clog2-derived ADDR_W function.
REQ-031 Scoreboard as sub-module regfile_scoreboard (busy vector, REQ-020..025); data array and bypass in regfile_sb top.
REQ-032 Read ports built by generate loop over N_RD; no per-port copy-paste.

Verification
REQ-033 Write 0xDEADBEEF to r5, next cycle read r5 on all ports -> 0xDEADBEEF, rd_busy=0.
REQ-034 Write 0x12345678 to r0, read r0 -> 0x00000000 same and next cycle; iss_addr=0 -> rd_busy stays 0.
REQ-035 Write r7=0xA5A5A5A5 while reading r7 same cycle -> rd_data=0xA5A5A5A5, rd_busy=0 combinationally.
REQ-036 Issue r3, read r3 -> rd_busy=1 for cycles until wr_en r3 arrives; same-cycle iss r3 + wr r3 -> busy=1 after edge, data updated.
REQ-037 Load r1..r31 with index values, assert reset with wr_en=1 to r9 -> after edge all reads 0, all busy 0.
REQ-038 NUM_REGS=24, DATA_W=16, N_RD=3: write to addr 28 ignored, read addr 28 -> 0; r23 write/read round-trips.
